// File: rtl/mult_seq_pkg.sv
// mult_seq shared types.
// State encoding for the sequential multiplier FSM.
package mult_seq_pkg;

    // Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_seq_twos_comp_n.sv
// twos_comp_n: combinational N-bit two's complement negate.
// Used for operand magnitudes and for the final product sign fix-up.
module twos_comp_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] x_i,
    output logic [N-1:0] y_o
);

    // Negate: invert and add one.
    assign y_o = ~x_i + N'(1);

endmodule

// File: rtl/mult_seq.sv
// mult_seq: radix-2 shift-add multiplier, signed or unsigned per op.
// One multiplier bit per cycle, then a sign fix-up cycle.
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mult_state_e        state_q;
    logic [WIDTH-1:0]   mcnd_q;
    logic [WIDTH-1:0]   mplr_q;
    logic [WIDTH-1:0]   acc_hi_q;
    logic [WIDTH-1:0]   acc_lo_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   a_inv_d;
    logic [WIDTH-1:0]   b_inv_d;
    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;
    logic [WIDTH-1:0]   addend_d;
    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [2*WIDTH-1:0] prod_inv_d;
    logic [2*WIDTH-1:0] res_d;

    twos_comp_n #(.N(WIDTH)) u_neg_a (
        .x_i (A),
        .y_o (a_inv_d)
    );

    twos_comp_n #(.N(WIDTH)) u_neg_b (
        .x_i (B),
        .y_o (b_inv_d)
    );

    twos_comp_n #(.N(2*WIDTH)) u_neg_p (
        .x_i (prod_d),
        .y_o (prod_inv_d)
    );

    // Operand magnitudes; the most-negative value maps to 2^(W-1) unsigned.
    always_comb begin
        a_mag_d = (SIGNED && A[WIDTH-1]) ? a_inv_d : A;
        b_mag_d = (SIGNED && B[WIDTH-1]) ? b_inv_d : B;
    end

    // Partial-product add with carry-out, and the signed result.
    always_comb begin
        addend_d = mplr_q[0] ? mcnd_q : '0;
        sum_d    = {1'b0, acc_hi_q} + {1'b0, addend_d};
        prod_d   = {acc_hi_q, acc_lo_q};
        res_d    = neg_q ? prod_inv_d : prod_d;
    end

    // Control FSM and datapath registers with registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            mcnd_q   <= '0;
            mplr_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        mcnd_q   <= a_mag_d;
                        mplr_q   <= b_mag_d;
                        neg_q    <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
                        acc_hi_q <= '0;
                        acc_lo_q <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_hi_q <= sum_d[WIDTH:1];
                    acc_lo_q <= {sum_d[0], acc_lo_q[WIDTH-1:1]};
                    mplr_q   <= mplr_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_q    <= res_d[2*WIDTH-1:WIDTH];
                    lo_q    <= res_d[WIDTH-1:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
